// File: rtl/weight_load_ctrl_if.sv
// Bundles the weight stream, memory write port and preload read port of weight_load_ctrl.
// The controller takes the slave view; the host/DMA and the array side together take the master view.
interface weight_load_ctrl_if #(
    parameter int DATA_W  = 5,
    parameter int ADDR_W  = 6,
    parameter int ROW_LEN = 8
);
    localparam int COL_W = $clog2(ROW_LEN);
    localparam int ROW_W = ADDR_W - COL_W;

    // weight stream from host/DMA
    logic              start;
    logic              w_valid;
    logic [DATA_W-1:0] w_data;
    logic              w_ready;

    // write port towards Weight_Memory
    logic [ADDR_W-1:0] Weight_Mem_Address_in;
    logic [DATA_W-1:0] Weight_Data;
    logic              load_mem_done;

    // preload read port towards the systolic-array controller
    logic              preload_req;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [ROW_W-1:0]  row_idx;
    logic [COL_W-1:0]  col_idx;
    logic              rd_last;

    // status
    logic              loaded;
    logic              busy;

    modport slave (
        input  start, w_valid, w_data, preload_req,
        output w_ready, Weight_Mem_Address_in, Weight_Data, load_mem_done,
               rd_en, rd_addr, row_idx, col_idx, rd_last, loaded, busy
    );

    modport master (
        output start, w_valid, w_data, preload_req,
        input  w_ready, Weight_Mem_Address_in, Weight_Data, load_mem_done,
               rd_en, rd_addr, row_idx, col_idx, rd_last, loaded, busy
    );
endinterface

// File: rtl/weight_load_ctrl.sv
// Weight memory sequencer: writes a DEPTH-beat weight stream into memory (LOAD),
// then replays row-major read addresses to the systolic array on request (PRELOAD).
module weight_load_ctrl #(
    parameter int DATA_W  = 5,
    parameter int ADDR_W  = 6,
    parameter int DEPTH   = 64,
    parameter int ROW_LEN = 8
) (
    input  logic              clk,
    input  logic              rst,
    weight_load_ctrl_if.slave bus
);
    localparam int COL_W = $clog2(ROW_LEN);
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  WCNT_FULL  = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] RADDR_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_LOADED,
        S_PRELOAD
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  wcnt_q, wcnt_d;
    logic              w_ready_q, w_ready_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wgate_q, wgate_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_last_q, rd_last_d;
    logic              loaded_q, loaded_d;
    logic              busy_q, busy_d;
    logic              accept;

    assign accept = bus.w_valid && w_ready_q;

    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        w_ready_d = w_ready_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        wgate_d   = 1'b1;
        rd_en_d   = rd_en_q;
        rd_addr_d = rd_addr_q;
        rd_last_d = rd_last_q;
        loaded_d  = loaded_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d   = S_LOAD;
                    wcnt_d    = '0;
                    w_ready_d = 1'b1;
                    loaded_d  = 1'b0;
                end
            end

            S_LOAD: begin
                if (accept) begin
                    waddr_d = wcnt_q[ADDR_W-1:0];
                    wdata_d = bus.w_data;
                    wgate_d = 1'b0;
                    wcnt_d  = wcnt_q + CNT_W'(1);
                end
                // A restart still lets this cycle's accepted beat be written above.
                if (bus.start) begin
                    wcnt_d    = '0;
                    w_ready_d = 1'b1;
                end else if (wcnt_q == WCNT_FULL) begin
                    state_d   = S_LOADED;
                    loaded_d  = 1'b1;
                    w_ready_d = 1'b0;
                end else begin
                    w_ready_d = (wcnt_d != WCNT_FULL);
                end
            end

            S_LOADED: begin
                if (bus.start) begin
                    state_d   = S_LOAD;
                    wcnt_d    = '0;
                    w_ready_d = 1'b1;
                    loaded_d  = 1'b0;
                end else if (bus.preload_req) begin
                    state_d   = S_PRELOAD;
                    rd_en_d   = 1'b1;
                    rd_addr_d = '0;
                    rd_last_d = (rd_addr_d == RADDR_LAST);
                end
            end

            S_PRELOAD: begin
                if (rd_last_q) begin
                    state_d   = S_LOADED;
                    rd_en_d   = 1'b0;
                    rd_last_d = 1'b0;
                end else begin
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                    rd_last_d = (rd_addr_d == RADDR_LAST);
                end
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_LOAD) || (state_d == S_PRELOAD);
    end

    always_ff @(posedge clk) begin
        // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q   <= S_IDLE;
            wcnt_q    <= '0;
            w_ready_q <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            wgate_q   <= 1'b1;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_last_q <= 1'b0;
            loaded_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            w_ready_q <= w_ready_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            wgate_q   <= wgate_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            rd_last_q <= rd_last_d;
            loaded_q  <= loaded_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.w_ready               = w_ready_q;
    assign bus.Weight_Mem_Address_in = waddr_q;
    assign bus.Weight_Data           = wdata_q;
    assign bus.load_mem_done         = wgate_q;
    assign bus.rd_en                 = rd_en_q;
    assign bus.rd_addr               = rd_addr_q;
    assign bus.row_idx               = rd_addr_q[ADDR_W-1:COL_W];
    assign bus.col_idx               = rd_addr_q[COL_W-1:0];
    assign bus.rd_last               = rd_last_q;
    assign bus.loaded                = loaded_q;
    assign bus.busy                  = busy_q;
endmodule

// File: tb/tb_weight_load_ctrl.sv
// Self-checking bench for weight_load_ctrl: a vector table for reset/idle behaviour,
// a write scoreboard for the load phase, and hand sequences for preload, restart and reset.
module tb_weight_load_ctrl;
    localparam int DATA_W  = 5;
    localparam int ADDR_W  = 6;
    localparam int DEPTH   = 64;
    localparam int ROW_LEN = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    weight_load_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ROW_LEN(ROW_LEN)) bus ();

    weight_load_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .ROW_LEN(ROW_LEN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        string name;
        int rst, start, w_valid, preload, w_data;
        int e_ready, e_lmd, e_rden, e_loaded, e_busy, e_addr, e_data;
    } vec_t;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    vec_t vecs[7];
    wr_t  exp_wr[$];
    bit   pending;
    bit   in_load;
    int   last_addr;
    int   last_data;
    int   n_writes;
    int   total;
    int   bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic raw_step();
        @(posedge clk);
        #1;
    endtask

    // Advance one cycle and score the memory write port against the expectation queue.
    task automatic step();
        bit was_rst;
        wr_t e;
        was_rst = rst;
        raw_step();
        if (was_rst) begin
            exp_wr.delete();
            pending   = 1'b0;
            last_addr = 0;
            last_data = 0;
        end
        check("load_mem_done", bus.load_mem_done, !pending);
        if (!bus.load_mem_done && exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            check("wr_addr", bus.Weight_Mem_Address_in, e.addr);
            check("wr_data", bus.Weight_Data, e.data);
            last_addr = e.addr;
            last_data = e.data;
            n_writes++;
        end else if (in_load && bus.load_mem_done) begin
            check("hold_addr", bus.Weight_Mem_Address_in, last_addr);
            check("hold_data", bus.Weight_Data, last_data);
        end
        pending = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_w_ready"}, bus.w_ready, 0);
        check({tag, "_lmd"},     bus.load_mem_done, 1);
        check({tag, "_addr"},    bus.Weight_Mem_Address_in, 0);
        check({tag, "_data"},    bus.Weight_Data, 0);
        check({tag, "_rd_en"},   bus.rd_en, 0);
        check({tag, "_rd_addr"}, bus.rd_addr, 0);
        check({tag, "_row"},     bus.row_idx, 0);
        check({tag, "_col"},     bus.col_idx, 0);
        check({tag, "_rd_last"}, bus.rd_last, 0);
        check({tag, "_loaded"},  bus.loaded, 0);
        check({tag, "_busy"},    bus.busy, 0);
    endtask

    // gap=1 toggles w_valid; restart_at/rst_at >= 0 fire start/rst alongside that beat.
    task automatic load_seq(input int gap, input int restart_at, input int rst_at);
        int beats;
        int cyc;
        int wr_total;
        bit restarted;
        bit v;
        bit do_rst;
        bit do_restart;
        logic [DATA_W-1:0] d;
        beats     = 0;
        cyc       = 0;
        restarted = 1'b0;
        n_writes  = 0;
        in_load   = 1'b1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("ready_after_start", bus.w_ready, 1);
        check("busy_load", bus.busy, 1);
        check("loaded_clr_on_load", bus.loaded, 0);

        while (beats < DEPTH) begin
            check("w_ready_in_load", bus.w_ready, 1);
            check("loaded_in_load", bus.loaded, 0);
            v          = (gap == 0) || (cyc % 2 == 0);
            d          = DATA_W'(cyc % 32);
            do_rst     = v && (beats == rst_at);
            do_restart = v && (beats == restart_at) && !restarted;
            bus.w_valid = v;
            bus.w_data  = d;
            bus.start   = do_restart;
            rst         = do_rst;
            if (v && !do_rst) begin
                exp_wr.push_back('{beats, int'(d)});
                pending = 1'b1;
            end
            step();
            bus.start   = 1'b0;
            bus.w_valid = 1'b0;
            if (do_rst) begin
                rst     = 1'b0;
                in_load = 1'b0;
                check_reset_vals("rst_mid_load");
                return;
            end
            if (v) beats++;
            if (do_restart) begin
                beats     = 0;
                restarted = 1'b1;
            end
            cyc++;
        end

        check("w_ready_drop", bus.w_ready, 0);
        check("loaded_at_last_write", bus.loaded, 0);
        check("busy_at_last_write", bus.busy, 1);
        bus.w_valid = 1'b1;
        step();
        bus.w_valid = 1'b0;
        check("loaded_set", bus.loaded, 1);
        check("busy_after_load", bus.busy, 0);
        check("w_ready_after_load", bus.w_ready, 0);
        wr_total = restarted ? DEPTH + restart_at + 1 : DEPTH;
        check("write_count", n_writes, wr_total);
        in_load = 1'b0;
    endtask

    // misuse drives start/preload_req/w_valid during the burst; rst_at >= 0 aborts at that address.
    task automatic preload_seq(input bit misuse, input int rst_at);
        bus.preload_req = 1'b1;
        step();
        bus.preload_req = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            check("rd_en", bus.rd_en, 1);
            check("rd_addr", bus.rd_addr, i);
            check("row_idx", bus.row_idx, i / ROW_LEN);
            check("col_idx", bus.col_idx, i % ROW_LEN);
            check("rd_last", bus.rd_last, (i == DEPTH - 1));
            check("busy_preload", bus.busy, 1);
            check("loaded_preload", bus.loaded, 1);
            check("w_ready_preload", bus.w_ready, 0);
            if (i == rst_at) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                check_reset_vals("rst_mid_preload");
                return;
            end
            if (misuse) begin
                bus.start       = (i % 3 == 0);
                bus.preload_req = (i % 5 == 1);
                bus.w_valid     = 1'b1;
                bus.w_data      = DATA_W'(i % 32);
            end
            step();
        end
        bus.start       = 1'b0;
        bus.preload_req = 1'b0;
        bus.w_valid     = 1'b0;
        check("rd_en_end", bus.rd_en, 0);
        check("rd_last_end", bus.rd_last, 0);
        check("busy_end", bus.busy, 0);
        check("loaded_end", bus.loaded, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad = 0;
        pending = 1'b0;
        in_load = 1'b0;
        last_addr = 0;
        last_data = 0;
        n_writes = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.w_valid = 1'b0;
        bus.w_data = '0;
        bus.preload_req = 1'b0;

        //           name            rst st wv pr wd  rdy lmd rde ld bsy addr data
        vecs[0] = '{"reset",          1, 0, 0, 0, 0,  0,  1,  0,  0, 0,  0,  0};
        vecs[1] = '{"w_valid_idle",   0, 0, 1, 0, 5,  0,  1,  0,  0, 0,  0,  0};
        vecs[2] = '{"preload_idle",   0, 0, 0, 1, 0,  0,  1,  0,  0, 0,  0,  0};
        vecs[3] = '{"start",          0, 1, 0, 0, 0,  1,  1,  0,  0, 1,  0,  0};
        vecs[4] = '{"first_beat",     0, 0, 1, 0, 17, 1,  0,  0,  0, 1,  0,  17};
        vecs[5] = '{"rst_with_beat",  1, 0, 1, 0, 9,  0,  1,  0,  0, 0,  0,  0};
        vecs[6] = '{"w_valid_post",   0, 0, 1, 0, 3,  0,  1,  0,  0, 0,  0,  0};

        repeat (2) raw_step();

        foreach (vecs[k]) begin
            rst             = (vecs[k].rst != 0);
            bus.start       = (vecs[k].start != 0);
            bus.w_valid     = (vecs[k].w_valid != 0);
            bus.preload_req = (vecs[k].preload != 0);
            bus.w_data      = DATA_W'(vecs[k].w_data);
            raw_step();
            check({vecs[k].name, "_w_ready"}, bus.w_ready, vecs[k].e_ready);
            check({vecs[k].name, "_lmd"},     bus.load_mem_done, vecs[k].e_lmd);
            check({vecs[k].name, "_rd_en"},   bus.rd_en, vecs[k].e_rden);
            check({vecs[k].name, "_loaded"},  bus.loaded, vecs[k].e_loaded);
            check({vecs[k].name, "_busy"},    bus.busy, vecs[k].e_busy);
            check({vecs[k].name, "_addr"},    bus.Weight_Mem_Address_in, vecs[k].e_addr);
            check({vecs[k].name, "_data"},    bus.Weight_Data, vecs[k].e_data);
        end
        rst = 1'b0;
        bus.start = 1'b0;
        bus.w_valid = 1'b0;
        bus.preload_req = 1'b0;

        load_seq(0, -1, -1);
        preload_seq(1'b0, -1);
        preload_seq(1'b0, -1);
        load_seq(1, -1, -1);
        load_seq(0, 20, -1);
        preload_seq(1'b1, -1);
        preload_seq(1'b0, 40);

        bus.preload_req = 1'b1;
        step();
        bus.preload_req = 1'b0;
        check("no_read_from_idle", bus.rd_en, 0);
        check("idle_not_busy", bus.busy, 0);

        load_seq(0, -1, 30);
        step();
        check("idle_after_load_rst", bus.busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/weight_load_ctrl.md
Name: weight_load_ctrl

Overview:
- Sequences the 64x5-bit weight memory.
- LOAD phase: accepts a valid/ready stream of 64 weights, generates write addresses 0..63 and drives the memory's active-low write gate `load_mem_done`.
- PRELOAD phase: on request from the systolic-array controller, issues 64 row-major read addresses, tagged with row/column indices, so the array can shift weights in.
- Sits between the host/DMA weight stream and Weight_Memory.

Parameters:
- DATA_W, 5, weight width
- ADDR_W, 6, memory address width
- DEPTH, 64, number of weights per load (must equal 2**ADDR_W)
- ROW_LEN, 8, weights per array row (DEPTH/ROW_LEN rows)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse: begin a new weight load
- w_valid  in  1  input weight beat valid
- w_data  in  DATA_W  input weight
- w_ready  out  1  controller accepts beat
- Weight_Mem_Address_in  out  ADDR_W  memory write address
- Weight_Data  out  DATA_W  memory write data
- load_mem_done  out  1  0 = memory writes this cycle; 1 = memory holds
- preload_req  in  1  pulse: stream weights to array
- rd_en  out  1  read address valid
- rd_addr  out  ADDR_W  memory read address
- row_idx  out  3  row of current read (rd_addr[5:3])
- col_idx  out  3  column of current read (rd_addr[2:0])
- rd_last  out  1  final read of preload
- loaded  out  1  memory holds a complete weight set
- busy  out  1  state is LOAD or PRELOAD

Behaviour:
- Fixed: one clock `clk`; `rst` is synchronous and active-high. All outputs are registered.
- Reset values:
  - state=IDLE.
  - load_mem_done=1, w_ready=0, rd_en=0, rd_last=0, loaded=0, busy=0.
  - All addresses, indices and Weight_Data = 0.
- States: IDLE, LOAD, LOADED, PRELOAD.
- IDLE:
  - start -> LOAD, with write counter wcnt=0.
  - preload_req is ignored.
- LOAD:
  - w_ready=1 until 64 beats have been accepted.
  - Beat accepted when w_valid&w_ready.
  - Next cycle: Weight_Mem_Address_in=wcnt, Weight_Data=w_data, load_mem_done=0 for exactly that cycle; wcnt increments.
  - No accept -> load_mem_done=1, address/data hold.
  - Write latency: 1 cycle from accept to memory write.
  - On the 64th accept (wcnt=63): w_ready drops the next cycle; after that final write, state -> LOADED and loaded=1.
  - The wcnt wrap 63->0 is not used as a completion signal; a 7-bit count or explicit flag is used.
  - start during LOAD restarts: wcnt=0, loaded stays 0; any beat accepted in the same cycle is still written, then the restart applies.
- LOADED:
  - preload_req -> PRELOAD with rcnt=0.
  - start -> LOAD; loaded clears when LOAD is entered.
  - start and preload_req in the same cycle: start wins.
- PRELOAD:
  - One read per cycle, rcnt 0..63: rd_en=1, rd_addr=rcnt, row_idx=rcnt[5:3], col_idx=rcnt[2:0].
  - First rd_en appears 1 cycle after preload_req.
  - rd_last=1 with rcnt=63.
  - Next cycle: rd_en=0, state -> LOADED; weights may be preloaded again.
  - start and preload_req during PRELOAD are ignored.
  - load_mem_done=1 throughout (no writes).
- w_valid outside LOAD: w_ready=0, data dropped, no write.
- rst in any state, mid-burst: next edge returns to reset values. Memory contents are not the controller's concern; loaded=0.
- busy=1 in LOAD and PRELOAD.

Test Plan:
- Reset, then start, then 64 back-to-back beats w_data=i%32 -> 64 writes at addr 0..63, each 1 cycle after accept; load_mem_done low exactly 64 cycles; loaded=1 the cycle after the last write; w_ready=0 afterwards.
- Load with w_valid toggling every other cycle -> load_mem_done low only in cycles after accepts; addr/data hold between; 64 writes total, no duplicate address.
- Full load then preload_req -> 64 consecutive rd_en cycles, rd_addr 0..63, row_idx/col_idx = addr[5:3]/addr[2:0], rd_last only at addr 63, then LOADED. A second preload_req repeats the identical sequence.
- start asserted after 20 beats -> restart at addr 0; 64 further beats required before loaded=1.
- Misuse: w_valid while IDLE/PRELOAD, preload_req while IDLE, start during PRELOAD -> no writes, no reads from IDLE, PRELOAD sequence unbroken.
- rst asserted mid-LOAD (after 30 beats) and mid-PRELOAD (at addr 40) -> next cycle all outputs at reset values, state IDLE, loaded=0.
